// File: rtl/fix_ctrl_batcher_pkg.sv
// -----------------------------------------------------------------------------
// fix_ctrl_p: shared types and helpers for the fix_ctrl_batcher slice.
//   fix_ctrl_state_e : batcher FSM states (FILL while the window is filling,
//                      RUN once DEPTH valid inputs have been seen).
//   SelWidth()       : width of the packed window / sel bus.
//   CntWidth()       : width of the decimation counter for a given ratio.
// -----------------------------------------------------------------------------
package fix_ctrl_p;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } fix_ctrl_state_e;

  function automatic int SelWidth(input int n_ctrl, input int depth);
    return n_ctrl * depth;
  endfunction

  function automatic int CntWidth(input int dsr);
    return $clog2(dsr);
  endfunction

endpackage

// File: rtl/fix_ctrl_batcher_window.sv
// -----------------------------------------------------------------------------
// fix_ctrl_window: DEPTH-entry shift register of N_CTRL-bit control vectors.
//   clk      in   clock, posedge
//   rstPulse in   asynchronous active-high clear
//   in_valid in   shift enable; ctrl_in enters slot 0 when high
//   ctrl_in  in   N_CTRL-bit control vector
//   shifted  out  combinational view of the window as it will look after
//                 this edge if in_valid is high (newest in the LSBs), so the
//                 parent can snapshot the post-shift window on the same edge
// Slot k lives at bits [k*N_CTRL +: N_CTRL].
// -----------------------------------------------------------------------------
module fix_ctrl_window
  import fix_ctrl_p::*;
#(
  parameter int N_CTRL = 4,
  parameter int DEPTH  = 8
) (
  input  logic                               clk,
  input  logic                               rstPulse,
  input  logic                               in_valid,
  input  logic [N_CTRL-1:0]                  ctrl_in,
  output logic [SelWidth(N_CTRL, DEPTH)-1:0] shifted
);

  localparam int W = SelWidth(N_CTRL, DEPTH);

  logic [W-1:0] win_q;

  generate
    if (DEPTH == 1) begin : g_single
      assign shifted = ctrl_in;
    end else begin : g_multi
      // Oldest slot drops off the top; newest enters slot 0.
      assign shifted = {win_q[W-N_CTRL-1:0], ctrl_in};
    end
  endgenerate

  always_ff @(posedge clk or posedge rstPulse) begin
    if (rstPulse) begin
      win_q <= '0;
    end else if (in_valid) begin
      win_q <= shifted;
    end
  end

endmodule

// File: rtl/fix_ctrl_batcher.sv
// -----------------------------------------------------------------------------
// fix_ctrl_batcher: upstream feeder for the fixed-point cumulative LUT stage.
// Keeps a sliding window of the last DEPTH control vectors and, every DSR
// accepted inputs (once the window is full), snapshots it onto sel and
// strobes sample. sel then holds for the whole decimation period.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rstPulse   in   asynchronous active-high reset
//   in_valid   in   ctrl_in is valid this cycle
//   ctrl_in    in   N_CTRL-bit control vector
//   sel        out  N_CTRL*DEPTH window snapshot
//   sample     out  one-cycle strobe, sel updated on the same edge
//   primed     out  window has held DEPTH valid inputs since reset
//   sample_cnt out  CNT_W-bit strobe count, wraps
//
// Handshake: in_valid is a qualifier only; there is no ready, so every cycle
// with in_valid=1 is an accepted input and cycles with in_valid=0 change
// nothing except clearing a pending sample strobe.
//
// Build option: FIX_CTRL_REVERSE_EN writes the snapshot time-reversed
// (oldest sample in slot 0) for the backward-recursion LUT. The internal
// shift register is the same either way.
//
// The FSM state is held in state_q (fix_ctrl_state_e) for checker binding.
// -----------------------------------------------------------------------------
module fix_ctrl_batcher
  import fix_ctrl_p::*;
#(
  parameter int N_CTRL = 4,
  parameter int DEPTH  = 8,
  parameter int DSR    = 4,
  parameter int CNT_W  = 16
) (
  input  logic                               clk,
  input  logic                               rstPulse,
  input  logic                               in_valid,
  input  logic [N_CTRL-1:0]                  ctrl_in,
  output logic [SelWidth(N_CTRL, DEPTH)-1:0] sel,
  output logic                               sample,
  output logic                               primed,
  output logic [CNT_W-1:0]                   sample_cnt
);

  localparam int SW = SelWidth(N_CTRL, DEPTH);
  localparam int DW = CntWidth(DSR);
  localparam int FW = $clog2(DEPTH + 1);

  localparam logic [DW-1:0] DEC_LAST  = DW'(DSR - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  generate
    if (DSR < 2 || DEPTH < 1 || N_CTRL < 1) begin : g_bad_cfg
      $fatal(1, "fix_ctrl_batcher: need DSR >= 2, DEPTH >= 1, N_CTRL >= 1");
    end
  endgenerate

  fix_ctrl_state_e state_q, state_d;
  logic [DW-1:0]   dec_q;
  logic [FW-1:0]   fill_q, fill_d, fill_after;
  logic [SW-1:0]   shifted, snap;
  logic            emit;

  fix_ctrl_window #(
    .N_CTRL (N_CTRL),
    .DEPTH  (DEPTH)
  ) u_window (
    .clk      (clk),
    .rstPulse (rstPulse),
    .in_valid (in_valid),
    .ctrl_in  (ctrl_in),
    .shifted  (shifted)
  );

  // Fill count including the current input, saturating at DEPTH.
  always_comb begin
    fill_after = fill_q;
    if (fill_q != FILL_FULL) begin
      fill_after = fill_q + 1'b1;
    end
  end

  // An unprimed wrap still wraps the counter but emits nothing.
  assign emit = in_valid && (dec_q == DEC_LAST) && (fill_after == FILL_FULL);

  // Snapshot mapping of the post-shift window.
`ifdef FIX_CTRL_REVERSE_EN
  always_comb begin
    snap = '0;
    for (int k = 0; k < DEPTH; k++) begin
      snap[k*N_CTRL +: N_CTRL] = shifted[(DEPTH-1-k)*N_CTRL +: N_CTRL];
    end
  end
`else
  assign snap = shifted;
`endif

  // FSM next-state and fill counter.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          fill_d = fill_after;
          if (fill_after == FILL_FULL) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstPulse) begin
    if (rstPulse) begin
      state_q <= FILL;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // primed rises on the same edge as the FILL->RUN transition.
  assign primed = (state_q == RUN);

  always_ff @(posedge clk or posedge rstPulse) begin
    if (rstPulse) begin
      dec_q      <= '0;
      sel        <= '0;
      sample     <= 1'b0;
      sample_cnt <= '0;
    end else begin
      sample <= emit;
      if (in_valid) begin
        dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
      end
      if (emit) begin
        sel        <= snap;
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fix_ctrl_batcher.sv
// -----------------------------------------------------------------------------
// Bench for fix_ctrl_batcher. Two instances share one stimulus stream:
// dut_a (N_CTRL=2, DEPTH=3, DSR=4) and dut_b (N_CTRL=2, DEPTH=6, DSR=4).
// The reference model keeps the accepted-input history and count and
// derives every expected output from them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fix_ctrl_batcher;

  localparam int N_CTRL = 2;
  localparam int DSR    = 4;
  localparam int CNT_W  = 16;

`ifdef FIX_CTRL_REVERSE_EN
  localparam logic [5:0] BASIC_SEL = 6'h39;
  localparam bit         REVERSED  = 1'b1;
`else
  localparam logic [5:0] BASIC_SEL = 6'h1B;
  localparam bit         REVERSED  = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstPulse;
  logic in_valid;
  logic [N_CTRL-1:0] ctrl_in;

  always #5 clk = ~clk;

  logic [5:0]       sel_a;
  logic             sample_a, primed_a;
  logic [CNT_W-1:0] cnt_a;
  logic [11:0]      sel_b;
  logic             sample_b, primed_b;
  logic [CNT_W-1:0] cnt_b;

  fix_ctrl_batcher #(.N_CTRL(2), .DEPTH(3), .DSR(DSR), .CNT_W(CNT_W)) dut_a (
    .clk        (clk),
    .rstPulse   (rstPulse),
    .in_valid   (in_valid),
    .ctrl_in    (ctrl_in),
    .sel        (sel_a),
    .sample     (sample_a),
    .primed     (primed_a),
    .sample_cnt (cnt_a)
  );

  fix_ctrl_batcher #(.N_CTRL(2), .DEPTH(6), .DSR(DSR), .CNT_W(CNT_W)) dut_b (
    .clk        (clk),
    .rstPulse   (rstPulse),
    .in_valid   (in_valid),
    .ctrl_in    (ctrl_in),
    .sel        (sel_b),
    .sample     (sample_b),
    .primed     (primed_b),
    .sample_cnt (cnt_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] exp_q[$];   // expected sel values for dut_a strobes, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               depth_of[2] = '{3, 6};
  int               n_acc;
  logic [1:0]       hist[$];
  logic [11:0]      e_sel[2];
  logic             e_sample[2];
  logic [CNT_W-1:0] e_cnt[2];

  function automatic logic [11:0] window_of(input int depth);
    logic [11:0] r = '0;
    int          sz = hist.size();
    for (int k = 0; k < depth; k++) begin
      if (REVERSED) r[k*2 +: 2] = hist[sz - depth + k];
      else          r[k*2 +: 2] = hist[sz - 1 - k];
    end
    return r;
  endfunction

  task automatic model_reset();
    n_acc = 0;
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      e_sel[i]    = '0;
      e_sample[i] = 1'b0;
      e_cnt[i]    = '0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [1:0] d);
    for (int i = 0; i < 2; i++) e_sample[i] = 1'b0;
    if (v) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      n_acc++;
      for (int i = 0; i < 2; i++) begin
        if ((n_acc % DSR) == 0 && n_acc >= depth_of[i]) begin
          e_sel[i]    = window_of(depth_of[i]);
          e_sample[i] = 1'b1;
          e_cnt[i]    = e_cnt[i] + 1'b1;
          if (i == 0) exp_q.push_back(e_sel[0][5:0]);
        end
      end
    end
  endtask

  task automatic check_all();
    check("sel_a",    32'(sel_a),    32'(e_sel[0][5:0]));
    check("sample_a", 32'(sample_a), 32'(e_sample[0]));
    check("primed_a", 32'(primed_a), 32'(n_acc >= depth_of[0]));
    check("cnt_a",    32'(cnt_a),    32'(e_cnt[0]));
    check("sel_b",    32'(sel_b),    32'(e_sel[1]));
    check("sample_b", 32'(sample_b), 32'(e_sample[1]));
    check("primed_b", 32'(primed_b), 32'(n_acc >= depth_of[1]));
    check("cnt_b",    32'(cnt_b),    32'(e_cnt[1]));
    if (sample_a === 1'b1) begin
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("strobe_sel", 32'(sel_a), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [1:0] d);
    @(negedge clk);
    in_valid = v;
    ctrl_in  = d;
    @(posedge clk);
    #1;
    model_edge(v, d);
    check_all();
  endtask

  // Asserted between edges: outputs must clear before the next posedge.
  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstPulse = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rstPulse = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstPulse = 1'b1;
    in_valid = 1'b0;
    ctrl_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstPulse = 1'b0;
    #1;
    check_all();

    // Basic emit, then the depth-6 instance's unprimed wrap and first emit.
    step(1'b1, 2'd0);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    check("basic_primed", 32'(primed_a), 32'd1);
    step(1'b1, 2'd3);
    check("basic_sel",    32'(sel_a),    32'(BASIC_SEL));
    check("basic_sample", 32'(sample_a), 32'd1);
    check("basic_cnt",    32'(cnt_a),    32'd1);
    check("unprimed_b",   32'(sample_b), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i));
    check("wrap_b_sample", 32'(sample_b), 32'd1);
    check("wrap_b_primed", 32'(primed_b), 32'd1);
    check("wrap_b_cnt",    32'(cnt_b),    32'd1);
    step(1'b0, 2'd0);
    check("strobe_width", 32'(sample_b), 32'd0);

    // Valid gaps before the 4th input.
    async_reset();
    step(1'b1, 2'd0);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom_range(0, 3)));
    step(1'b1, 2'd3);
    check("gap_sel",    32'(sel_a),    32'(BASIC_SEL));
    check("gap_sample", 32'(sample_a), 32'd1);

    // Continuous run of 12 inputs.
    async_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 2'($urandom_range(0, 3)));
    check("cont_cnt", 32'(cnt_a), 32'd3);

    // Mid-count reset, then 4 fresh inputs give exactly one strobe.
    step(1'b1, 2'd2);
    step(1'b1, 2'd1);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i));
    check("midrst_sel", 32'(sel_a), 32'(BASIC_SEL));
    check("midrst_cnt", 32'(cnt_a), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
